btb_bimodal: RTL
================

# btb_bimodal

Parametrised branch target buffer with per-entry saturating direction counters and configurable associativity. It replaces the fixed-size, mispredict-only-update BTB in the fetch stage. Lookup is combinational from the fetch PC. Update is registered from the decode-stage branch resolution on every resolved branch, so the direction counters train on every outcome.

## Interface
Parameters:
- XLEN, 32: address/target width.
- ENTRIES, 64: total entries; power of two, ≥ WAYS.
- WAYS, 2: associativity; 1 or 2.
- CTR_BITS, 2: direction counter width, 1..3.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all valid bits, counters and replacement bits.
- Branch  in  1  fetch instruction is a branch (lookup qualifier).
- PC  in  XLEN  fetch PC.
- Prediction  out  1  predict taken.
- PredictedTarget  out  XLEN  target for a taken prediction.
- UpdateEnable  in  1  resolved branch in decode; update this cycle.
- BranchTaken  in  1  resolved direction.
- PCUpdate  in  XLEN  PC of the resolved branch.
- PCBranch  in  XLEN  resolved target.
- Flush  in  1  invalidate all entries (context switch or self-modifying code).
- Hit  out  1  tag match, for performance counters.

## Operation
- SETS = ENTRIES/WAYS. IDX = log2(SETS). Index = addr[IDX+1:2]. Tag = addr[XLEN-1:IDX+2].
- Each way holds: valid, tag, target[XLEN-1:0], ctr[CTR_BITS-1:0]. Each set has one round-robin victim bit (ignored when WAYS=1).
- Lookup is combinational:
  - Hit = Branch & any valid way with tag match.
  - Prediction = Hit & ctr[CTR_BITS-1] of the hitting way.
  - PredictedTarget = target of the hitting way when Hit, else 0.
  - Multiple matching ways cannot occur; allocation guarantees tag uniqueness within a set.
- Update with UpdateEnable=1 and a tag hit:
  - Counter saturating increment if BranchTaken, decrement otherwise. Saturates at 2^CTR_BITS-1 and 0.
  - If BranchTaken, target is overwritten with PCBranch.
- Update with UpdateEnable=1 and a miss:
  - Not taken: no allocation.
  - Taken: allocate into the lowest-numbered invalid way, else into the victim way. Victim bit toggles on every victim allocation.
  - Allocated entry: valid=1, tag, target=PCBranch, ctr = 2^(CTR_BITS-1) (weakly taken).
- Flush clears every valid bit; counters, targets and victim bits are retained. Flush has priority over a same-cycle update; that update is dropped.
- reset has priority over Flush and update. It clears valid, ctr and victim bits. Targets and tags are don't-care after reset.

## Timing
- Lookup latency: 0 cycles, combinational from PC and Branch.
- Update latency: written on the clk edge where UpdateEnable=1; visible to lookup the next cycle.
- Same-cycle lookup and update on the same set: lookup returns pre-update state. No internal bypass.
- Reset values: Prediction=0, Hit=0, PredictedTarget=0, because all entries are invalid.
- Reset asserted mid-update: the update is discarded and the state is cleared.
- UpdateEnable held high with identical inputs: each cycle counts as a separate training event.

## Structure
- Shared package btb_pkg holds:
  - the way-entry struct (valid/tag/target/ctr);
  - localparam functions for IDX and tag width;
  - CTR_INIT = 1 << (CTR_BITS-1).
- Sub-module sat_counter (CTR_BITS parameter, inc/dec/load inputs) is the natural extraction.
- Storage is flops, not inferred RAM, because lookup is combinational and reset/Flush touch every entry.

## Test plan
- Reset, then lookup PC=0x100 with Branch=1 -> Prediction=0, Hit=0, PredictedTarget=0.
- Update PCUpdate=0x100, PCBranch=0x200, taken; next cycle lookup 0x100 -> Hit=1, Prediction=1, PredictedTarget=0x200.
- With CTR_BITS=2, train the 0x100 entry with two not-taken updates -> counter 2→1→0, Prediction=0, Hit=1. Three further taken updates -> counter saturates at 3.
- WAYS=2, ENTRIES=4: taken updates for 0x100, 0x108, 0x110 (same set 0) -> the third evicts way 0. Lookup 0x100 misses; 0x108 and 0x110 hit.
- Same-cycle Flush and taken update to 0x300 -> next cycle all lookups miss, including 0x300.
- Lookup 0x100 in the same cycle as its first taken update -> Prediction=0 that cycle and 1 the next.

Source files
------------

// File: rtl/btb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : btb_pkg
//  Purpose  : Shared sizing helpers for the bimodal branch target buffer.
//             Entry geometry depends on module parameters, so the package
//             provides the functions that derive the index width, tag width
//             and the weakly-taken counter reset value.
//  Revision : 1.0  initial release
// ============================================================================
package btb_pkg;

    // Number of set-index bits: log2(ENTRIES / WAYS).
    function automatic int idx_bits(input int entries, input int ways);
        return $clog2(entries / ways);
    endfunction

    // Tag covers everything above the index; the two LSBs are word offset.
    function automatic int tag_bits(input int xlen, input int entries, input int ways);
        return xlen - idx_bits(entries, ways) - 2;
    endfunction

    // Freshly allocated entries start weakly taken (MSB set, rest clear).
    function automatic int ctr_init(input int ctr_bits);
        return 1 << (ctr_bits - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Saturating up/down counter with a parallel load of a fixed
//             value. Load wins over inc/dec; inc wins over dec.
//  Ports    : clk, reset  - clock, synchronous active-high reset (to 0)
//             inc_i       - increment, saturating at all-ones
//             dec_i       - decrement, saturating at zero
//             load_i      - load LOAD_VAL
//             count_o     - current count
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int               CTR_BITS = 2,
    parameter logic [CTR_BITS-1:0] LOAD_VAL = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc_i,
    input  logic                dec_i,
    input  logic                load_i,
    output logic [CTR_BITS-1:0] count_o
);
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};

    logic [CTR_BITS-1:0] count_q;
    logic [CTR_BITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VAL;
        end else if (inc_i) begin
            if (count_q != CTR_MAX) count_d = count_q + 1'b1;
        end else if (dec_i) begin
            if (count_q != '0) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/btb_bimodal.sv
`default_nettype none
// ============================================================================
//  Module   : btb_bimodal
//  Purpose  : Set-associative (1 or 2 way) branch target buffer with per-entry
//             saturating direction counters. Combinational lookup from the
//             fetch PC; registered update from every resolved branch.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             Branch, PC          - lookup qualifier and fetch PC
//             Prediction          - predict taken
//             PredictedTarget     - target of hitting way (0 on miss)
//             Hit                 - tag match (qualified by Branch)
//             UpdateEnable        - resolved branch this cycle
//             BranchTaken         - resolved direction
//             PCUpdate, PCBranch  - resolved branch PC and target
//             Flush               - invalidate all entries
//  Revision : 1.0  initial release
// ============================================================================
module btb_bimodal
    import btb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int WAYS     = 2,
    parameter int CTR_BITS = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Branch,
    input  logic [XLEN-1:0] PC,
    output logic            Prediction,
    output logic [XLEN-1:0] PredictedTarget,
    input  logic            UpdateEnable,
    input  logic            BranchTaken,
    input  logic [XLEN-1:0] PCUpdate,
    input  logic [XLEN-1:0] PCBranch,
    input  logic            Flush,
    output logic            Hit
);
    localparam int SETS     = ENTRIES / WAYS;
    localparam int IDX_BITS = idx_bits(ENTRIES, WAYS);
    // Keep a 1-bit index when there is only a single set.
    localparam int IDXW     = (IDX_BITS == 0) ? 1 : IDX_BITS;
    localparam int TAG_W    = tag_bits(XLEN, ENTRIES, WAYS);
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));

    // Way entry; the direction counter lives in its own sat_counter.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
    } btb_way_t;

    btb_way_t            entry_q [WAYS][SETS];
    btb_way_t            entry_d [WAYS][SETS];
    logic                victim_q [SETS];
    logic                victim_d [SETS];
    logic [CTR_BITS-1:0] w_ctr   [WAYS][SETS];

    logic [IDXW-1:0]  w_lk_set;
    logic [IDXW-1:0]  w_up_set;
    logic [TAG_W-1:0] w_lk_tag;
    logic [TAG_W-1:0] w_up_tag;
    logic [WAYS-1:0]  w_lk_match;
    logic [WAYS-1:0]  w_up_match;
    logic [WAYS-1:0]  w_alloc_oh;
    logic             w_up_hit;
    logic             w_any_invalid;
    logic             w_upd_act;
    logic             w_unused_lsbs;

    assign w_lk_tag      = PC[XLEN-1:IDX_BITS+2];
    assign w_up_tag      = PCUpdate[XLEN-1:IDX_BITS+2];
    assign w_unused_lsbs = ^{PC[1:0], PCUpdate[1:0]};

    if (IDX_BITS == 0) begin : g_idx_single
        assign w_lk_set = '0;
        assign w_up_set = '0;
    end else begin : g_idx_multi
        assign w_lk_set = PC[IDX_BITS+1:2];
        assign w_up_set = PCUpdate[IDX_BITS+1:2];
    end

    // ---------------------------------------------------------------- lookup
    always_comb begin
        w_lk_match      = '0;
        Prediction      = 1'b0;
        PredictedTarget = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (entry_q[w][w_lk_set].valid && entry_q[w][w_lk_set].tag == w_lk_tag)
                w_lk_match[w] = 1'b1;
        end
        // At most one way matches, so the last-match selection is exact.
        for (int w = 0; w < WAYS; w++) begin
            if (Branch && w_lk_match[w]) begin
                Prediction      = w_ctr[w][w_lk_set][CTR_BITS-1];
                PredictedTarget = entry_q[w][w_lk_set].target;
            end
        end
    end

    assign Hit = Branch & (|w_lk_match);

    // ------------------------------------------------- update-side matching
    always_comb begin
        w_up_match    = '0;
        w_alloc_oh    = '0;
        w_any_invalid = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (entry_q[w][w_up_set].valid && entry_q[w][w_up_set].tag == w_up_tag)
                w_up_match[w] = 1'b1;
        end
        // Lowest-numbered invalid way first, otherwise the round-robin victim.
        for (int w = 0; w < WAYS; w++) begin
            if (!entry_q[w][w_up_set].valid && !w_any_invalid) begin
                w_alloc_oh[w] = 1'b1;
                w_any_invalid = 1'b1;
            end
        end
        if (!w_any_invalid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAYS == 1 || w == int'(victim_q[w_up_set]))
                    w_alloc_oh[w] = 1'b1;
            end
        end
    end

    assign w_up_hit  = |w_up_match;
    // Flush drops any same-cycle update.
    assign w_upd_act = UpdateEnable & ~Flush;

    // ------------------------------------------------- tag/target/victim
    always_comb begin
        entry_d  = entry_q;
        victim_d = victim_q;
        if (Flush) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++)
                    entry_d[w][s].valid = 1'b0;
        end else if (UpdateEnable && BranchTaken) begin
            for (int w = 0; w < WAYS; w++) begin
                if (w_up_hit) begin
                    if (w_up_match[w]) entry_d[w][w_up_set].target = PCBranch;
                end else if (w_alloc_oh[w]) begin
                    entry_d[w][w_up_set].valid  = 1'b1;
                    entry_d[w][w_up_set].tag    = w_up_tag;
                    entry_d[w][w_up_set].target = PCBranch;
                end
            end
            if (!w_up_hit && !w_any_invalid)
                victim_d[w_up_set] = ~victim_q[w_up_set];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++)
                    entry_q[w][s].valid <= 1'b0;
            for (int s = 0; s < SETS; s++)
                victim_q[s] <= 1'b0;
        end else begin
            entry_q  <= entry_d;
            victim_q <= victim_d;
        end
    end

    // ------------------------------------------------- direction counters
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        for (genvar s = 0; s < SETS; s++) begin : g_set
            logic w_sel;
            assign w_sel = w_upd_act && (w_up_set == IDXW'(s));

            sat_counter #(
                .CTR_BITS (CTR_BITS),
                .LOAD_VAL (CTR_INIT)
            ) u_ctr (
                .clk     (clk),
                .reset   (reset),
                .inc_i   (w_sel && w_up_match[w] && BranchTaken),
                .dec_i   (w_sel && w_up_match[w] && !BranchTaken),
                .load_i  (w_sel && !w_up_hit && BranchTaken && w_alloc_oh[w]),
                .count_o (w_ctr[w][s])
            );
        end
    end

endmodule
`default_nettype wire
